// File: rtl/hci_mem_bank_pkg.sv
// Shared types, constants and helpers for the HCI memory bank responder.
// Optional grant-stall injection is enabled with HCI_MEM_BANK_STALL_EN.
package hci_mem_bank_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } bank_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int MAX_DW = 256;

    function automatic logic [MAX_DW-1:0] be_to_bitmask(
        input logic [MAX_DW-1:0] be,
        input int                bw
    );
        logic [MAX_DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            mask[8'(i)] = be[8'(i / bw)];
        end
        return mask;
    endfunction

endpackage

// File: rtl/hci_mem_bank_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; its LSB drives grant stalls.
// Only instantiated when HCI_MEM_BANK_STALL_EN is defined.
module hci_mem_bank_lfsr
    import hci_mem_bank_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    output logic lsb_o
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb  = ^(r_lfsr & LFSR_TAPS);
    assign lsb_o = r_lfsr[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

endmodule

// File: rtl/hci_mem_bank_responder.sv
// Single-port TCDM bank for the HCI log interconnect, 1-cycle responses.
// Define HCI_MEM_BANK_STALL_EN to inject pseudo-random grant stalls.
module hci_mem_bank_responder
    import hci_mem_bank_pkg::*;
#(
    parameter int NWORDS = 64,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int BW     = 8,
    parameter int UW     = 1,
    parameter int IW     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    output logic                         busy_o,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic [AW-1:0]                add_i,
    input  logic                         wen_i,
    input  logic [DW/BW-1:0]             be_i,
    input  logic [DW-1:0]                data_i,
    input  logic [((UW > 0) ? UW : 1)-1:0] user_i,
    input  logic [IW-1:0]                id_i,
    output logic                         r_valid_o,
    output logic [DW-1:0]                r_data_o,
    output logic [((UW > 0) ? UW : 1)-1:0] r_user_o,
    output logic [IW-1:0]                r_id_o
);

    localparam int IDXW = $clog2(NWORDS);
    localparam int UWI  = (UW > 0) ? UW : 1;

    bank_state_e     r_state;
    bank_state_e     w_state_nxt;
    logic [IDXW-1:0] r_cnt;
    logic [IDXW-1:0] w_cnt_nxt;

    logic [DW-1:0]   r_mem  [NWORDS];
    logic [UWI-1:0]  r_umem [NWORDS];

    logic            r_valid;
    logic [DW-1:0]   r_data;
    logic [UWI-1:0]  r_user;
    logic [IW-1:0]   r_id;

    logic            w_stall;
    logic            w_xfer;
    logic [IDXW-1:0] w_idx;
    logic [DW-1:0]   w_mask;
    logic            w_unused;

`ifdef HCI_MEM_BANK_STALL_EN
    hci_mem_bank_lfsr u_lfsr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .lsb_o (w_stall)
    );
`else
    assign w_stall = 1'b0;
`endif

    assign w_idx    = add_i[IDXW+1:2];
    assign w_unused = ^{add_i[AW-1:IDXW+2], add_i[1:0], user_i};
    assign w_mask   = DW'(be_to_bitmask(MAX_DW'(be_i), BW));

    assign busy_o = (r_state == INIT);
    assign gnt_o  = (r_state == READY) & req_i & ~w_stall;
    assign w_xfer = req_i & gnt_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (clear_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == IDXW'(NWORDS - 1)) begin
                    w_state_nxt = READY;
                    w_cnt_nxt   = '0;
                end
            end
            READY: begin
                if (clear_i) begin
                    w_state_nxt = INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage is never reset; the fill sequence defines its contents.
    always_ff @(posedge clk_i) begin
        if (r_state == INIT) begin
            r_mem[r_cnt]  <= '0;
            r_umem[r_cnt] <= '0;
        end else if (w_xfer && !wen_i) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (data_i & w_mask);
            if (|be_i) begin
                r_umem[w_idx] <= user_i;
            end
        end
    end

    // Response carries the word as it was before this edge's write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= '0;
            r_id    <= '0;
        end else begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= r_mem[w_idx];
                r_user <= r_umem[w_idx];
                r_id   <= id_i;
            end
        end
    end

    assign r_valid_o = r_valid;
    assign r_data_o  = r_data;
    assign r_user_o  = (UW > 0) ? r_user : '0;
    assign r_id_o    = r_id;

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Randomised and directed bench for hci_mem_bank_responder.
// Works for both the default and the HCI_MEM_BANK_STALL_EN build.
module tb_hci_mem_bank_responder;

    localparam int NW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_i;
    logic        busy_o;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] add_i;
    logic        wen_i;
    logic [3:0]  be_i;
    logic [31:0] data_i;
    logic [0:0]  user_i;
    logic [7:0]  id_i;
    logic        r_valid_o;
    logic [31:0] r_data_o;
    logic [0:0]  r_user_o;
    logic [7:0]  r_id_o;

    always #5 clk = ~clk;

    hci_mem_bank_responder #(
        .NWORDS (NW),
        .AW     (32),
        .DW     (32),
        .BW     (8),
        .UW     (1),
        .IW     (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (clear_i),
        .busy_o    (busy_o),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .add_i     (add_i),
        .wen_i     (wen_i),
        .be_i      (be_i),
        .data_i    (data_i),
        .user_i    (user_i),
        .id_i      (id_i),
        .r_valid_o (r_valid_o),
        .r_data_o  (r_data_o),
        .r_user_o  (r_user_o),
        .r_id_o    (r_id_o)
    );

    int          n_vec  = 0;
    int          n_err  = 0;
    int          n_gnt  = 0;
    int          n_rv   = 0;
    int          n_stall = 0;
    logic [31:0] mdl_d [NW];
    logic        mdl_u [NW];
    logic [31:0] last_rdata;
    logic [7:0]  last_rid;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < NW; i++) begin
            mdl_d[i] = '0;
            mdl_u[i] = 1'b0;
        end
    endtask

    // Called at a falling edge; drives one cycle and checks its response.
    task automatic step(input bit rq, input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        input logic u, input logic [7:0] id,
                        input bit clr_on_gnt, output bit g);
        bit          ev;
        logic [31:0] ed;
        logic        eu;
        int          k;
        req_i  = rq;
        wen_i  = w;
        add_i  = a;
        be_i   = b;
        data_i = d;
        user_i = u;
        id_i   = id;
        #1;
`ifndef HCI_MEM_BANK_STALL_EN
        if (!busy_o) chk("gnt_follows_req", 64'(gnt_o), 64'(rq));
`else
        chk("gnt_implies_req", 64'(gnt_o & ~rq), 64'(0));
        if (rq && !busy_o && !gnt_o) n_stall++;
`endif
        if (busy_o) chk("gnt_held_off", 64'(gnt_o), 64'(0));
        g  = rq & gnt_o;
        ev = g;
        ed = '0;
        eu = 1'b0;
        if (g) begin
            n_gnt++;
            k  = int'(a[7:2]);
            ed = mdl_d[k];
            eu = mdl_u[k];
            if (!w) begin
                for (int j = 0; j < 4; j++)
                    if (b[j]) mdl_d[k][j*8 +: 8] = d[j*8 +: 8];
                if (|b) mdl_u[k] = u;
            end
            if (clr_on_gnt) begin
                clear_i = 1'b1;
                mdl_clear();
            end
        end
        @(negedge clk);
        clear_i = 1'b0;
        if (r_valid_o) n_rv++;
        chk("r_valid", 64'(r_valid_o), 64'(ev));
        if (ev) begin
            chk("r_data", 64'(r_data_o), 64'(ed));
            chk("r_user", 64'(r_user_o), 64'(eu));
            chk("r_id", 64'(r_id_o), 64'(id));
            last_rdata = r_data_o;
            last_rid   = r_id_o;
        end
    endtask

    task automatic idle();
        bit g;
        step(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 8'h0, 1'b0, g);
    endtask

    // Holds the request until granted; returns the number of cycles used.
    task automatic xfer(input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        input logic u, input logic [7:0] id,
                        input bit clr, output int cyc);
        bit g;
        g   = 1'b0;
        cyc = 0;
        while (!g && cyc < 64) begin
            step(1'b1, w, a, b, d, u, id, clr, g);
            cyc++;
        end
        if (!g) chk("grant_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cyc;
        int steps;
        logic [31:0] a;
        bit rq;

        rst     = 1'b1;
        clear_i = 1'b0;
        req_i   = 1'b1;
        wen_i   = 1'b1;
        add_i   = '0;
        be_i    = '0;
        data_i  = '0;
        user_i  = '0;
        id_i    = 8'h01;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 64'(gnt_o), 64'(0));
        chk("rst_rvalid", 64'(r_valid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(1));
        chk("rst_rdata", 64'(r_data_o), 64'(0));
        chk("rst_rid", 64'(r_id_o), 64'(0));
        chk("rst_ruser", 64'(r_user_o), 64'(0));

        // Fill after reset, request held high throughout.
        rst = 1'b0;
        #1;
        n = 0;
        while (busy_o && n < 200) begin
            chk("init_gnt", 64'(gnt_o), 64'(0));
            n++;
            @(negedge clk);
            #1;
        end
        chk("init_cycles", 64'(n), 64'(NW));
        mdl_clear();
        xfer(1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 8'h01, 1'b0, cyc);
        chk("first_read", 64'(last_rdata), 64'(0));

        // Full write then read-after-write.
        xfer(1'b0, 32'h8, 4'hF, 32'hDEADBEEF, 1'b1, 8'h5A, 1'b0, cyc);
        chk("wr_id", 64'(last_rid), 64'(8'h5A));
        xfer(1'b1, 32'h8, 4'h0, 32'h0, 1'b0, 8'h3C, 1'b0, cyc);
        chk("raw_data", 64'(last_rdata), 64'(32'hDEADBEEF));
        chk("raw_id", 64'(last_rid), 64'(8'h3C));

        // Partial byte-enable write.
        xfer(1'b0, 32'h14, 4'hF, 32'hAAAAAAAA, 1'b0, 8'h11, 1'b0, cyc);
        xfer(1'b0, 32'h14, 4'b0101, 32'h11223344, 1'b1, 8'h12, 1'b0, cyc);
        xfer(1'b1, 32'h14, 4'h0, 32'h0, 1'b0, 8'h13, 1'b0, cyc);
        chk("partial", 64'(last_rdata), 64'(32'hAA22AA44));

        // Back-to-back reads of words 0..7.
        steps = 0;
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, 32'(i * 4), 4'h0, 32'h0, 1'b0, 8'(8'h20 + i), 1'b0, cyc);
            steps += cyc;
        end
`ifndef HCI_MEM_BANK_STALL_EN
        chk("b2b_cycles", 64'(steps), 64'(8));
`endif

        // Clear alongside a granted write to word 3.
        xfer(1'b0, 32'hC, 4'hF, 32'hFFFFFFFF, 1'b1, 8'h77, 1'b1, cyc);
        n = 0;
        while (busy_o && n < 200) begin
            n++;
            idle();
        end
        chk("clear_busy_cycles", 64'(n), 64'(NW));
        xfer(1'b1, 32'hC, 4'h0, 32'h0, 1'b0, 8'h78, 1'b0, cyc);
        chk("clear_word3", 64'(last_rdata), 64'(0));

        // Random traffic with idle gaps and aliased upper address bits.
        for (int i = 0; i < 1000; i++) begin
            rq = ($urandom_range(0, 3) != 0);
            a  = $urandom();
            a[7:2] = 6'($urandom_range(0, 7));
            if (rq)
                xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
                     $urandom(), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 1'b0, cyc);
            else
                idle();
        end
        chk("rvalid_per_grant", 64'(n_rv), 64'(n_gnt));
`ifdef HCI_MEM_BANK_STALL_EN
        chk("stall_seen", 64'(n_stall > 0), 64'(1));
`endif

        // Reset while a response is pending.
        req_i = 1'b1;
        wen_i = 1'b1;
        add_i = 32'h0;
        #1;
        n = 0;
        while (!gnt_o && n < 64) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("mid_gnt", 64'(gnt_o), 64'(1));
        @(posedge clk);
        #1;
        chk("mid_pending", 64'(r_valid_o), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 64'(r_valid_o), 64'(0));
        chk("mid_rst_busy", 64'(busy_o), 64'(1));
        chk("mid_rst_gnt", 64'(gnt_o), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hci_mem_bank_responder.md
Name: hci_mem_bank_responder

Overview:
- Memory-side responder for the HCI memory protocol: one word-wide TCDM bank that sits on a single mem port of the log interconnect.
- Accepts req/add/wen/be/data/user/id, grants, and returns r_data/r_user/r_id with a fixed 1-cycle response latency.
- Writes also produce a response (r_valid), matching the interconnect's write-response-on, 1-cycle-latency configuration.
- Contains a register-based storage array plus an init FSM that zero-fills the bank after reset or on request.

Parameters:
- NWORDS, 64, words in the bank; power of two, at least 2.
- AW, 32, address width; byte address, word aligned.
- DW, 32, data width in bits.
- BW, 8, bits per byte-enable lane; DW/BW byte enables.
- UW, 1, user bits per word; 0 allowed, in which case user is ignored and r_user_o is 0.
- IW, 8, request id width, echoed on the response.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- clear_i  in  1  pulse: restart zero-fill of the whole bank
- busy_o  out  1  high while the init FSM is filling
- req_i  in  1  request valid
- gnt_o  out  1  request granted
- add_i  in  AW  byte address; word index = add_i[$clog2(NWORDS)+1:2], all other bits ignored
- wen_i  in  1  1 = read, 0 = write
- be_i  in  DW/BW  byte enables (writes only)
- data_i  in  DW  write data
- user_i  in  max(UW,1)  write user bits
- id_i  in  IW  request id
- r_valid_o  out  1  response valid
- r_data_o  out  DW  read data
- r_user_o  out  max(UW,1)  read user bits
- r_id_o  out  IW  echoed id

Behaviour:
- Clock and reset: single clock clk_i; rst_i is an asynchronous, active-high reset.
- Reset values: gnt_o=0, r_valid_o=0, r_data_o=0, r_user_o=0, r_id_o=0, busy_o=1, FSM=INIT, fill counter=0. Array contents are undefined until INIT completes.
- FSM INIT:
  - Writes zero to data and user of word[cnt], then cnt++.
  - gnt_o=0 for the whole fill; incoming req_i is held off, not dropped.
  - After cnt==NWORDS-1 is written: go to READY, busy_o=0. Fill takes exactly NWORDS cycles.
- FSM READY:
  - gnt_o = req_i, combinational, same cycle. No backpressure other than the optional stall feature.
- Handshake:
  - A transfer occurs on req_i & gnt_o at a rising edge.
  - The initiator holds all request fields stable until granted.
- Read transfer (wen_i=1) in cycle T: at T+1, r_valid_o=1, r_data_o/r_user_o = word contents at edge T, r_id_o=id_i captured at T.
- Write transfer (wen_i=0) in cycle T:
  - Byte lane k of the word is updated iff be_i[k].
  - User bits are written iff any be_i bit is set.
  - At T+1: r_valid_o=1, r_data_o = pre-write word value (don't-care for the initiator, but deterministic), r_id_o echoed.
- r_valid_o is high for exactly one cycle per transfer.
- Back-to-back transfers: one per cycle, full throughput.
- Read-after-write to the same word in consecutive cycles returns the new data.
- No response for an ungranted request; r_valid_o=0 in every cycle following a cycle with no transfer.
- clear_i in READY:
  - Next cycle enters INIT with cnt=0 and busy_o=1.
  - A transfer granted in the same cycle as clear_i still completes, including its response.
- clear_i during INIT: cnt restarts at 0.
- Reset mid-operation: any pending response is discarded (r_valid_o=0), FSM=INIT.
- Upper address bits outside the word index alias; no error is reported.

Optional Feature:
- Macro: HCI_MEM_BANK_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advances every cycle.
  - In READY, gnt_o = req_i & ~lfsr[0], injecting pseudo-random grant stalls.
  - Granted transfers behave identically to the non-stall build.
- Not defined: no LFSR is built and gnt_o = req_i in READY.

Decomposition:
- Package hci_mem_bank_pkg:
  - bank_state_e {INIT, READY}
  - LFSR_SEED and LFSR_TAPS constants
  - function be_to_bitmask(be) expanding DW/BW byte enables to a DW-bit mask.
- Sub-module hci_mem_bank_lfsr (16-bit LFSR, enable-free): instantiated only under HCI_MEM_BANK_STALL_EN.

Test Plan:
- Reset with NWORDS=64, req_i held at 1 from reset release -> gnt_o=0 and busy_o=1 for exactly 64 cycles, first grant in cycle 65, read of word 0 returns 0.
- Write add=0x8, be=4'b1111, data=0xDEADBEEF, id=0x5A; then read add=0x8, id=0x3C -> write response r_valid at T+1 with r_id=0x5A; read returns 0xDEADBEEF with r_id=0x3C.
- Partial write be=4'b0101, data=0x11223344 over a word holding 0xAAAAAAAA -> subsequent read returns 0xAA22AA44.
- Back-to-back reads of words 0..7 with req held high -> gnt_o high every cycle, eight consecutive r_valid pulses with matching ids, no gaps.
- clear_i pulsed in the same cycle as a granted write of 0xFFFFFFFF to word 3 -> write response still issued; busy_o high for 64 cycles; word 3 then reads 0.
- With HCI_MEM_BANK_STALL_EN, 1000 random reads/writes -> a scoreboard against a reference model shows zero mismatches, at least one stall cycle, and exactly one r_valid per granted request.
